// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers used by the round-robin arbiters.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_PORTS = 64;

  // Round-robin mask after granting idx: ports strictly past idx in the
  // search direction. An all-zero result sends selection back to the raw encoder.
  function automatic logic [ARB_MAX_PORTS-1:0] rr_mask(input int idx, input logic lsb_low);
    logic [ARB_MAX_PORTS-1:0] m;
    for (int i = 0; i < ARB_MAX_PORTS; i++)
      m[i] = lsb_low ? (i > idx) : (i < idx);
    return m;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: LOW picks the lowest set bit, HIGH the highest.
module priority_encoder #(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded
);

  localparam int EW = $clog2(WIDTH);

  assign output_valid = |input_unencoded;

  always_comb begin
    output_encoded = '0;
    if (LSB_PRIORITY == "LOW") begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (input_unencoded[i]) output_encoded = EW'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (input_unencoded[i]) output_encoded = EW'(i);
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with configurable grant hold policy.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int    PORTS         = 4,
  parameter int    ARB_BLOCK     = 1,
  parameter int    ARB_BLOCK_ACK = 1,
  parameter string LSB_PRIORITY  = "LOW"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int   IW      = $clog2(PORTS);
  localparam logic LSB_LOW = (LSB_PRIORITY == "LOW");

  arb_state_e             state, state_nxt;
  logic [PORTS-1:0]       mask, mask_nxt;
  logic [PORTS-1:0]       grant_nxt;
  logic [IW-1:0]          enc_nxt;
  logic [PORTS-1:0]       req_masked;
  logic                   raw_valid, msk_valid;
  logic [IW-1:0]          raw_idx, msk_idx;
  logic                   cand_valid;
  logic [IW-1:0]          cand_idx;
  logic                   rel;
  logic [ARB_MAX_PORTS-1:0] full_mask;

  assign req_masked = request & mask;

  priority_encoder #(.WIDTH(PORTS), .LSB_PRIORITY(LSB_PRIORITY)) u_enc_raw (
    .input_unencoded (request),
    .output_valid    (raw_valid),
    .output_encoded  (raw_idx)
  );

  priority_encoder #(.WIDTH(PORTS), .LSB_PRIORITY(LSB_PRIORITY)) u_enc_msk (
    .input_unencoded (req_masked),
    .output_valid    (msk_valid),
    .output_encoded  (msk_idx)
  );

  // Masked candidate continues the rotation; raw candidate handles wrap-around.
  assign cand_valid = msk_valid | raw_valid;
  assign cand_idx   = msk_valid ? msk_idx : raw_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      grant_encoded <= '0;
      mask          <= '1;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      grant_encoded <= enc_nxt;
      mask          <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    enc_nxt   = grant_encoded;
    mask_nxt  = mask;
    full_mask = '0;
    rel       = 1'b1;
    if (ARB_BLOCK != 0)
      rel = (ARB_BLOCK_ACK != 0) ? acknowledge[grant_encoded] : !request[grant_encoded];
    if (state == ARB_IDLE || rel) begin
      if (cand_valid) begin
        state_nxt = ARB_GRANTED;
        grant_nxt = {{(PORTS-1){1'b0}}, 1'b1} << cand_idx;
        enc_nxt   = cand_idx;
        full_mask = rr_mask(int'(cand_idx), LSB_LOW);
        mask_nxt  = full_mask[PORTS-1:0];
      end else begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    end
  end

  always_comb grant_valid = |grant;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench: three arbiter policies share stimulus, each checked against a rotation model.
module tb_rr_grant_arbiter;

  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] request = '0;
  logic [P-1:0] acknowledge = '0;

  logic [P-1:0] g0, g1, g2;
  logic         v0, v1, v2;
  logic [1:0]   e0, e1, e2;

  int tests = 0;
  int fails = 0;

  // Expectation per cycle: -2 reset, -1 no grant, else granted index.
  int q0[$], q1[$], q2[$];
  int cur[3];
  int last[3];

  always #5 clk = ~clk;

  rr_grant_arbiter #(.PORTS(P), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_PRIORITY("LOW")) dut_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g0), .grant_valid(v0), .grant_encoded(e0));

  rr_grant_arbiter #(.PORTS(P), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_PRIORITY("LOW")) dut_rr (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g1), .grant_valid(v1), .grant_encoded(e1));

  rr_grant_arbiter #(.PORTS(P), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_PRIORITY("LOW")) dut_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g2), .grant_valid(v2), .grant_encoded(e2));

  // Next port after the last winner that is requesting, wrapping to the lowest.
  function automatic int pick(input logic [P-1:0] req, input int lst);
    for (int i = lst + 1; i < P; i++) if (req[i]) return i;
    for (int i = 0; i < P; i++) if (req[i]) return i;
    return -1;
  endfunction

  function automatic logic [P-1:0] gack(input int k);
    logic [P-1:0] one;
    one = 1;
    return (cur[k] >= 0) ? (one << cur[k]) : '0;
  endfunction

  task automatic step(input logic r, input logic [P-1:0] req, input logic [P-1:0] ack);
    @(negedge clk);
    rst = r; request = req; acknowledge = ack;
    for (int k = 0; k < 3; k++) begin
      int  e;
      bit  rl;
      if (r) begin
        cur[k] = -1; last[k] = -1; e = -2;
      end else begin
        if (cur[k] < 0) rl = 1'b1;
        else if (k == 0) rl = ack[cur[k]];
        else if (k == 1) rl = 1'b1;
        else rl = !req[cur[k]];
        if (rl) begin
          cur[k] = pick(req, last[k]);
          if (cur[k] >= 0) last[k] = cur[k];
        end
        e = cur[k];
      end
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int e, input logic [P-1:0] g, input logic v, input logic [1:0] en);
    logic [P-1:0] eg;
    logic [P-1:0] one;
    one = 1;
    eg = (e >= 0) ? (one << e) : '0;
    tests++;
    if (g !== eg || v !== (e >= 0)) begin
      fails++;
      $display("FAIL %s grant: got %b valid %b, want %b valid %b", nm, g, v, eg, e >= 0);
    end
    if (e != -1) begin
      tests++;
      if (en !== ((e >= 0) ? 2'(e) : 2'd0)) begin
        fails++;
        $display("FAIL %s grant_encoded: got %0d, want %0d", nm, en, (e >= 0) ? e : 0);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) chk("ack_mode", q0.pop_front(), g0, v0, e0);
      if (q1.size() > 0) chk("rearb_mode", q1.pop_front(), g1, v1, e1);
      if (q2.size() > 0) chk("req_mode", q2.pop_front(), g2, v2, e2);
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin cur[k] = -1; last[k] = -1; end
    // Reset held with all requesting, then first grant goes to port 0.
    repeat (4) step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    // Rotation 0->1->2->3->0->1 with acknowledge on the owner.
    repeat (5) step(1'b0, 4'b1111, gack(0));
    // Spurious acknowledge on non-granted ports while port 1 owns the grant.
    step(1'b0, 4'b1111, 4'b1101);
    step(1'b0, 4'b1111, 4'b0010);
    // Port 2 drops request without acknowledge: ack-mode grant holds.
    repeat (2) step(1'b0, 4'b1011, 4'b0000);
    step(1'b0, 4'b0001, 4'b0100);
    // Move to port 3, then release with it as sole requester.
    step(1'b0, 4'b1000, 4'b0001);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000);
    // Steady 0101: re-arbitrating instance alternates.
    repeat (6) step(1'b0, 4'b0101, 4'b0000);
    // Idle and reset mid-grant.
    step(1'b0, 4'b0000, 4'b1111);
    step(1'b0, 4'b0110, 4'b0000);
    step(1'b1, 4'b0110, 4'b0100);
    for (int n = 0; n < 400; n++) begin
      logic [P-1:0] rq, ak;
      rq = P'($urandom);
      case ($urandom_range(0, 3))
        0: ak = P'($urandom);
        1, 2: ak = gack(0);
        default: ak = '0;
      endcase
      step($urandom_range(0, 99) < 2, rq, ak);
    end
    step(1'b0, 4'b0000, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", q0.size() + q1.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
